// File: rtl/sdram_rmw_bridge.sv
// sdram_rmw_bridge: 16-bit CPU accesses onto 32-bit SDRAM word pulses, with a one-word read buffer and read-modify-write for partial writes
//   clk, rst_n                   clock and synchronous active-low reset
//   cpu_req/we/addr/be/wdata     CPU request, held until cpu_ack
//   cpu_rdata/ack/err            completion pulse, read halfword, timeout flag
//   sd_address/req_read/req_write/wdata   word request to the controller
//   sd_rdata/data_valid/write_complete    controller responses (rising edges complete)
module sdram_rmw_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [23:0] cpu_addr,
    input  logic [1:0]  cpu_be,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [23:0] sd_address,
    output logic        sd_req_read,
    output logic        sd_req_write,
    output logic [31:0] sd_wdata,
    input  logic [31:0] sd_rdata,
    input  logic        sd_data_valid,
    input  logic        sd_write_complete
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, MERGE, WR_ISSUE, WR_WAIT, ACK} state_t;

    state_t        state, state_nxt;
    logic [23:0]   addr;
    logic          we;
    logic [1:0]    be;
    logic [15:0]   wdata;
    logic [31:0]   buf_data;
    logic [22:0]   buf_tag;
    logic          buf_vld;
    logic          dv_prev, wc_prev, ack_prev, err;
    logic [CW-1:0] cnt;
    logic          hit, accept, rd_done, wr_done, waiting, expired;
    logic [15:0]   half, merged_half;
    logic [31:0]   merged;

    always_comb begin
        hit         = buf_vld && buf_tag == cpu_addr[23:1];
        // the request is still high in the cycle after ack; that is not a new access
        accept      = cpu_req && !ack_prev;
        rd_done     = sd_data_valid && !dv_prev;
        wr_done     = sd_write_complete && !wc_prev;
        waiting     = state == RD_WAIT || state == WR_WAIT;
        expired     = cnt == CW'(TIMEOUT - 1);
        half        = addr[0] ? buf_data[31:16] : buf_data[15:0];
        merged_half = {be[1] ? wdata[15:8] : half[15:8], be[0] ? wdata[7:0] : half[7:0]};
        merged      = addr[0] ? {merged_half, buf_data[15:0]} : {buf_data[31:16], merged_half};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = !cpu_we ? (hit ? ACK : RD_ISSUE) :
                                              cpu_be == 2'b00 ? ACK : hit ? MERGE : RD_ISSUE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = rd_done ? (we ? MERGE : ACK) : expired ? ACK : RD_WAIT;
            MERGE:    state_nxt = WR_ISSUE;
            WR_ISSUE: state_nxt = WR_WAIT;
            WR_WAIT:  state_nxt = (wr_done || expired) ? ACK : WR_WAIT;
            ACK:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_ack      = state == ACK;
        cpu_err      = cpu_ack && err;
        cpu_rdata    = (cpu_ack && !we && !err) ? half : 16'h0000;
        sd_req_read  = state == RD_ISSUE;
        sd_req_write = state == WR_ISSUE;
        sd_address   = {addr[23:1], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr     <= '0;
            we       <= 1'b0;
            be       <= '0;
            wdata    <= '0;
            err      <= 1'b0;
            buf_data <= '0;
            buf_tag  <= '0;
            buf_vld  <= 1'b0;
            dv_prev  <= 1'b0;
            wc_prev  <= 1'b0;
            ack_prev <= 1'b0;
            cnt      <= '0;
            sd_wdata <= '0;
        end else begin
            dv_prev  <= sd_data_valid;
            wc_prev  <= sd_write_complete;
            ack_prev <= cpu_ack;
            // zero on the first wait cycle, so the wait lasts TIMEOUT cycles
            cnt      <= waiting ? cnt + CW'(1) : '0;
            if (state == IDLE && accept) begin
                addr  <= cpu_addr;
                we    <= cpu_we;
                be    <= cpu_be;
                wdata <= cpu_wdata;
                err   <= 1'b0;
            end
            // a completion edge in the expiry cycle still wins
            if (state == RD_WAIT && rd_done) begin
                buf_data <= sd_rdata;
                buf_tag  <= addr[23:1];
                buf_vld  <= 1'b1;
            end else if (waiting && expired && !(state == WR_WAIT && wr_done)) begin
                buf_vld <= 1'b0;
                err     <= 1'b1;
            end
            // write-through: the buffer keeps the merged word
            if (state == MERGE) begin
                buf_data <= merged;
                sd_wdata <= merged;
            end
        end
    end
endmodule
